// File: rtl/adc_scan_controller.sv
// rtl/adc_scan_controller.sv - Round-robin ADC scan sequencer with debounced over/under-voltage supervision
//
// Walks the enabled channels, runs a start/done handshake with the shared ADC for each one,
// classifies each result against fixed thresholds and debounces it into per-channel flags.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   enable         in   scanning enabled
//   chan_mask      in   per-channel enable, bit i = channel i
//   adc_start      out  one-cycle conversion request
//   adc_chan       out  channel being converted
//   adc_done       in   conversion complete, adc_data valid in the same cycle
//   adc_data       in   conversion result
//   sample_valid   out  one-cycle pulse, sample_chan/sample_value valid
//   sample_chan    out  channel of the last evaluated sample
//   sample_value   out  last evaluated sample
//   over_voltage   out  debounced over-voltage flag per channel
//   under_voltage  out  debounced under-voltage flag per channel
//   fault_any      out  OR of all over/under flags
//   scan_done      out  one-cycle pulse at the end of each scan
//   timeout_err    out  sticky conversion-timeout flag
module adc_scan_controller #(
  parameter int ADC_WIDTH       = 12,
  parameter int NUM_CH          = 4,
  parameter int CH_BITS         = 2,
  parameter int UPPER_THRESHOLD = 3000,
  parameter int LOWER_THRESHOLD = 1000,
  parameter int DEBOUNCE        = 3,
  parameter int SCAN_INTERVAL   = 100,
  parameter int TIMEOUT         = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    chan_mask,
  output logic                 adc_start,
  output logic [CH_BITS-1:0]   adc_chan,
  input  logic                 adc_done,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic                 sample_valid,
  output logic [CH_BITS-1:0]   sample_chan,
  output logic [ADC_WIDTH-1:0] sample_value,
  output logic [NUM_CH-1:0]    over_voltage,
  output logic [NUM_CH-1:0]    under_voltage,
  output logic                 fault_any,
  output logic                 scan_done,
  output logic                 timeout_err
);

  localparam int CNT_W  = $clog2(DEBOUNCE + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int WAIT_W = $clog2(SCAN_INTERVAL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_CONVERT, S_EVAL, S_WAIT
  } state_t;

  state_t r_state, w_next;

  logic [CH_BITS-1:0]   r_ptr;
  logic [CH_BITS-1:0]   r_chan;
  logic [NUM_CH-1:0]    r_mask;
  logic [TO_W-1:0]      r_tcnt;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic                 r_timed_out;
  logic [ADC_WIDTH-1:0] r_data;
  logic                 r_sample_valid;
  logic [CH_BITS-1:0]   r_sample_chan;
  logic [ADC_WIDTH-1:0] r_sample_value;
  logic [NUM_CH-1:0]    r_over_flag;
  logic [NUM_CH-1:0]    r_under_flag;
  logic                 r_scan_done;
  logic                 r_timeout_err;
  logic [CNT_W-1:0]     r_over_cnt  [NUM_CH];
  logic [CNT_W-1:0]     r_under_cnt [NUM_CH];
  logic [CNT_W-1:0]     r_ok_cnt    [NUM_CH];

  logic                 w_sel_found;
  logic [CH_BITS-1:0]   w_sel_chan;
  logic                 w_more;
  logic                 w_to_expire;
  logic                 w_eval_upd;
  logic                 w_is_over;
  logic                 w_is_under;
  logic                 w_is_ok;
  logic                 w_adc_start;
  logic                 w_upd       [NUM_CH];
  logic [CNT_W-1:0]     w_over_nxt  [NUM_CH];
  logic [CNT_W-1:0]     w_under_nxt [NUM_CH];
  logic [CNT_W-1:0]     w_ok_nxt    [NUM_CH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_W'(DEBOUNCE)) return c;
    return c + CNT_W'(1);
  endfunction

  // Lowest live-mask channel at or above the pointer; iterating downward leaves the lowest hit.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_chan  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chan_mask[i] && (i >= int'(r_ptr))) begin
        w_sel_found = 1'b1;
        w_sel_chan  = CH_BITS'(i);
      end
    end
  end

  // "Another channel above" uses the mask captured at SELECT, so mid-conversion mask edits wait.
  always_comb begin
    w_more = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_mask[i] && (i > int'(r_chan))) w_more = 1'b1;
    end
  end

  assign w_to_expire = (r_state == S_CONVERT) && !adc_done && (r_tcnt == TO_W'(TIMEOUT - 1));
  assign w_eval_upd  = (r_state == S_EVAL) && !r_timed_out;
  assign w_is_over   = r_data > ADC_WIDTH'(UPPER_THRESHOLD);
  assign w_is_under  = r_data < ADC_WIDTH'(LOWER_THRESHOLD);
  assign w_is_ok     = !w_is_over && !w_is_under;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_upd[i]       = w_eval_upd && (r_chan == CH_BITS'(i));
      w_over_nxt[i]  = w_is_over  ? sat_inc(r_over_cnt[i])  : '0;
      w_under_nxt[i] = w_is_under ? sat_inc(r_under_cnt[i]) : '0;
      w_ok_nxt[i]    = w_is_ok    ? sat_inc(r_ok_cnt[i])    : '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a conversion in flight always runs through EVAL before honouring enable=0.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (enable && (chan_mask != '0)) w_next = S_SELECT;
      S_SELECT:  if (!enable)         w_next = S_IDLE;
                 else if (w_sel_found) w_next = S_START;
                 else                  w_next = S_WAIT;
      S_START:   w_next = S_CONVERT;
      S_CONVERT: if (adc_done || w_to_expire) w_next = S_EVAL;
      S_EVAL:    if (!enable)   w_next = S_IDLE;
                 else if (w_more) w_next = S_SELECT;
                 else             w_next = S_WAIT;
      S_WAIT:    if (!enable)   w_next = S_IDLE;
                 else if (r_wait_cnt == WAIT_W'(SCAN_INTERVAL)) w_next = S_SELECT;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_adc_start = 1'b0;
    if (r_state == S_START) w_adc_start = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr          <= '0;
      r_chan         <= '0;
      r_mask         <= '0;
      r_tcnt         <= '0;
      r_wait_cnt     <= '0;
      r_timed_out    <= 1'b0;
      r_data         <= '0;
      r_sample_valid <= 1'b0;
      r_sample_chan  <= '0;
      r_sample_value <= '0;
      r_scan_done    <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE || r_state == S_WAIT) r_ptr <= '0;
      if (r_state == S_EVAL && w_more)            r_ptr <= r_chan + CH_BITS'(1);
      if (r_state == S_IDLE || r_state == S_SELECT) r_mask <= chan_mask;
      if (r_state == S_SELECT && w_sel_found)       r_chan <= w_sel_chan;

      if (r_state == S_START)        r_tcnt <= '0;
      else if (r_state == S_CONVERT) r_tcnt <= r_tcnt + TO_W'(1);

      if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      else                   r_wait_cnt <= '0;

      if (r_state == S_CONVERT) begin
        if (adc_done) begin
          r_data      <= adc_data;
          r_timed_out <= 1'b0;
        end else if (w_to_expire) begin
          r_timed_out <= 1'b1;
        end
      end
      if (w_to_expire) r_timeout_err <= 1'b1;

      r_sample_valid <= w_eval_upd;
      if (w_eval_upd) begin
        r_sample_chan  <= r_chan;
        r_sample_value <= r_data;
      end
      r_scan_done <= ((r_state == S_SELECT) && enable && !w_sel_found) ||
                     ((r_state == S_EVAL) && !w_more);
    end
  end

  // Debounce counters and flags; the class counters are mutually exclusive so only one flag rule fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_over_flag  <= '0;
      r_under_flag <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_over_cnt[i]  <= '0;
        r_under_cnt[i] <= '0;
        r_ok_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_upd[i]) begin
          r_over_cnt[i]  <= w_over_nxt[i];
          r_under_cnt[i] <= w_under_nxt[i];
          r_ok_cnt[i]    <= w_ok_nxt[i];
          if (w_over_nxt[i] == CNT_W'(DEBOUNCE)) begin
            r_over_flag[i]  <= 1'b1;
            r_under_flag[i] <= 1'b0;
          end else if (w_under_nxt[i] == CNT_W'(DEBOUNCE)) begin
            r_over_flag[i]  <= 1'b0;
            r_under_flag[i] <= 1'b1;
          end else if (w_ok_nxt[i] == CNT_W'(DEBOUNCE)) begin
            r_over_flag[i]  <= 1'b0;
            r_under_flag[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign adc_start     = w_adc_start;
  assign adc_chan      = r_chan;
  assign sample_valid  = r_sample_valid;
  assign sample_chan   = r_sample_chan;
  assign sample_value  = r_sample_value;
  assign over_voltage  = r_over_flag;
  assign under_voltage = r_under_flag;
  assign fault_any     = |{r_over_flag, r_under_flag};
  assign scan_done     = r_scan_done;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_adc_scan_controller.sv
// tb/tb_adc_scan_controller.sv - Self-checking bench for adc_scan_controller
module tb_adc_scan_controller;

  localparam int NCH = 4;
  localparam int SI  = 100;
  localparam int TO  = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  chan_mask = '0;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        adc_start;
  logic [1:0]  adc_chan;
  logic        sample_valid;
  logic [1:0]  sample_chan;
  logic [11:0] sample_value;
  logic [3:0]  over_voltage;
  logic [3:0]  under_voltage;
  logic        fault_any;
  logic        scan_done;
  logic        timeout_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int start_chan_log[$];
  int start_cyc_log[$];
  int sv_chan_log[$];
  int sv_cyc_log[$];
  int scan_done_cyc[$];
  int exp_chan[$];
  int exp_val[$];
  int q_data[NCH][$];
  int dflt[NCH];
  bit hold[NCH];

  adc_scan_controller dut (
    .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
    .adc_start(adc_start), .adc_chan(adc_chan), .adc_done(adc_done), .adc_data(adc_data),
    .sample_valid(sample_valid), .sample_chan(sample_chan), .sample_value(sample_value),
    .over_voltage(over_voltage), .under_voltage(under_voltage), .fault_any(fault_any),
    .scan_done(scan_done), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // ADC model: answers each adc_start 3 cycles later and pushes the expected sample.
  initial begin : adc_model
    int cd;
    int ch;
    int v;
    cd = 0;
    ch = 0;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (!reset) cd = 0;
      else if (cd > 0) begin
        cd--;
        if (cd == 0 && !hold[ch]) begin
          if (q_data[ch].size() > 0) v = q_data[ch].pop_front();
          else v = dflt[ch];
          adc_done = 1'b1;
          adc_data = 12'(v);
          exp_chan.push_back(ch);
          exp_val.push_back(v);
        end
      end else if (adc_start) begin
        ch = int'(adc_chan);
        cd = 3;
      end
    end
  end

  // Scoreboard consumer and event logger.
  initial begin : monitor
    int ec;
    int ev;
    forever begin
      @(negedge clk);
      if (adc_start) begin
        start_chan_log.push_back(int'(adc_chan));
        start_cyc_log.push_back(cyc);
      end
      if (scan_done) scan_done_cyc.push_back(cyc);
      if (sample_valid) begin
        sv_chan_log.push_back(int'(sample_chan));
        sv_cyc_log.push_back(cyc);
        total++;
        if (exp_chan.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got chan=%0d value=%0d required no sample", sample_chan, sample_value);
        end else begin
          ec = exp_chan.pop_front();
          ev = exp_val.pop_front();
          if (int'(sample_chan) !== ec || int'(sample_value) !== ev) begin
            bad++;
            $display("FAIL sb_sample got chan=%0d value=%0d required chan=%0d value=%0d",
                     sample_chan, sample_value, ec, ev);
          end
        end
        total++;
        if ((over_voltage & under_voltage) !== 4'b0) begin
          bad++;
          $display("FAIL flag_exclusive got over=%b under=%b required disjoint", over_voltage, under_voltage);
        end
      end
    end
  end

  task automatic clear_logs();
    start_chan_log.delete();
    start_cyc_log.delete();
    sv_chan_log.delete();
    sv_cyc_log.delete();
    scan_done_cyc.delete();
  endtask

  task automatic go_idle();
    enable = 1'b0;
    repeat (20) @(negedge clk);
    clear_logs();
  endtask

  task automatic wait_scans(input int n, input string tag);
    int target;
    int t;
    target = scan_done_cyc.size() + n;
    t = 0;
    while (scan_done_cyc.size() < target) begin
      @(negedge clk);
      t++;
      if (t > n * 400) begin
        $display("FAIL wait_%s got scans=%0d required=%0d", tag, scan_done_cyc.size(), target);
        $fatal(1, "stalled");
      end
    end
  endtask

  task automatic wait_start(input int ch, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!(adc_start && int'(adc_chan) == ch)) begin
      @(negedge clk);
      t++;
      if (t > 400) begin
        $display("FAIL wait_%s got no adc_start required chan=%0d", tag, ch);
        $fatal(1, "stalled");
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b0;
    chan_mask = '0;
    for (int i = 0; i < NCH; i++) begin dflt[i] = 2000; hold[i] = 1'b0; end
    repeat (3) @(negedge clk);
    total++;
    if ({adc_start, adc_chan, sample_valid, sample_chan, sample_value, over_voltage,
         under_voltage, fault_any, scan_done, timeout_err} !== 29'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0", {adc_start, adc_chan, sample_valid, sample_chan,
               sample_value, over_voltage, under_voltage, fault_any, scan_done, timeout_err});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_scan();
    chan_mask = 4'hF;
    clear_logs();
    enable = 1'b1;
    wait_scans(2, "basic");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (start_chan_log[i] !== i) begin
        bad++;
        $display("FAIL basic_order[%0d] got=%0d required=%0d", i, start_chan_log[i], i);
      end
    end
    total++;
    if (sv_chan_log.size() !== 8) begin
      bad++;
      $display("FAIL basic_sv_count got=%0d required=8", sv_chan_log.size());
    end
    total++;
    if (sv_chan_log[3] !== 3 || sv_cyc_log[3] !== scan_done_cyc[0]) begin
      bad++;
      $display("FAIL basic_scan_done got chan=%0d cyc=%0d required chan=3 cyc=%0d",
               sv_chan_log[3], sv_cyc_log[3], scan_done_cyc[0]);
    end
    total++;
    if (start_cyc_log[4] - scan_done_cyc[0] !== SI + 2) begin
      bad++;
      $display("FAIL basic_interval got=%0d required=%0d", start_cyc_log[4] - scan_done_cyc[0], SI + 2);
    end
    total++;
    if ({over_voltage, under_voltage, fault_any, timeout_err} !== 10'd0) begin
      bad++;
      $display("FAIL basic_flags got over=%b under=%b fault=%b to=%b required 0",
               over_voltage, under_voltage, fault_any, timeout_err);
    end
  endtask

  task automatic test_over_debounce();
    logic [3:0] exp_over [9] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    int vals [9] = '{4000, 4000, 4000, 2000, 2000, 2000, 4000, 2000, 4000};
    bit ok;
    go_idle();
    chan_mask = 4'b0101;
    foreach (vals[i]) q_data[2].push_back(vals[i]);
    enable = 1'b1;
    for (int s = 0; s < 9; s++) begin
      wait_scans(1, "over");
      total++;
      if ({fault_any, over_voltage} !== {exp_over[s] != 4'h0, exp_over[s]}) begin
        bad++;
        $display("FAIL over_scan%0d got over=%b fault=%b required over=%b", s + 1, over_voltage, fault_any, exp_over[s]);
      end
    end
    ok = (start_chan_log.size() == 18);
    foreach (start_chan_log[i]) if (start_chan_log[i] != ((i % 2) * 2)) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL over_chan_seq got %0d starts required 18 alternating 0,2", start_chan_log.size());
    end
  endtask

  task automatic test_under_to_over();
    int vals [15] = '{500, 500, 500, 4000, 4000, 4000, 3000, 3000, 3000, 500, 500, 500, 1000, 1000, 1000};
    logic [1:0] exp_ou [15] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00,
                                2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    go_idle();
    chan_mask = 4'b0001;
    foreach (vals[i]) q_data[0].push_back(vals[i]);
    enable = 1'b1;
    for (int s = 0; s < 15; s++) begin
      wait_scans(1, "under");
      total++;
      if ({over_voltage[0], under_voltage[0]} !== exp_ou[s]) begin
        bad++;
        $display("FAIL under_scan%0d data=%0d got over,under=%b%b required=%b",
                 s + 1, vals[s], over_voltage[0], under_voltage[0], exp_ou[s]);
      end
    end
  endtask

  task automatic test_timeout();
    go_idle();
    chan_mask = 4'hF;
    hold[1] = 1'b1;
    enable = 1'b1;
    wait_scans(1, "timeout");
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_set got=%b required=1", timeout_err);
    end
    total++;
    if (sv_chan_log.size() !== 3 || sv_chan_log[0] !== 0 || sv_chan_log[1] !== 2 || sv_chan_log[2] !== 3) begin
      bad++;
      $display("FAIL timeout_skip got %0d samples required chans 0,2,3", sv_chan_log.size());
    end
    total++;
    if (start_chan_log[2] !== 2 || start_cyc_log[2] - start_cyc_log[1] !== TO + 3) begin
      bad++;
      $display("FAIL timeout_gap got chan=%0d gap=%0d required chan=2 gap=%0d",
               start_chan_log[2], start_cyc_log[2] - start_cyc_log[1], TO + 3);
    end
    hold[1] = 1'b0;
    wait_scans(1, "timeout2");
    total++;
    if (timeout_err !== 1'b1 || sv_chan_log.size() !== 7) begin
      bad++;
      $display("FAIL timeout_sticky got to=%b samples=%0d required to=1 samples=7", timeout_err, sv_chan_log.size());
    end
  endtask

  task automatic test_enable_drop();
    go_idle();
    chan_mask = 4'hF;
    enable = 1'b1;
    wait_start(1, "drop");
    @(negedge clk);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (sv_chan_log.size() !== 2 || sv_chan_log[1] !== 1) begin
      bad++;
      $display("FAIL drop_complete got %0d samples required 2 ending with chan 1", sv_chan_log.size());
    end
    total++;
    if (start_chan_log.size() !== 2 || scan_done_cyc.size() !== 0) begin
      bad++;
      $display("FAIL drop_idle got starts=%0d scan_done=%0d required starts=2 scan_done=0",
               start_chan_log.size(), scan_done_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    go_idle();
    chan_mask = 4'b0001;
    for (int i = 0; i < 3; i++) q_data[0].push_back(4000);
    enable = 1'b1;
    wait_scans(3, "rst_pre");
    total++;
    if (over_voltage !== 4'b0001) begin
      bad++;
      $display("FAIL rst_pre_over got=%b required=0001", over_voltage);
    end
    wait_start(0, "rst_conv");
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({adc_start, adc_chan, sample_valid, sample_chan, sample_value, over_voltage,
         under_voltage, fault_any, scan_done, timeout_err} !== 29'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs got=%h required=0", {adc_start, adc_chan, sample_valid, sample_chan,
               sample_value, over_voltage, under_voltage, fault_any, scan_done, timeout_err});
    end
    @(negedge clk);
    chan_mask = 4'hF;
    clear_logs();
    reset = 1'b1;
    wait_scans(1, "rst_post");
    total++;
    if (start_chan_log.size() < 4 || start_chan_log[0] !== 0 || start_chan_log[3] !== 3) begin
      bad++;
      $display("FAIL rst_restart got first=%0d count=%0d required first=0 count>=4",
               start_chan_log[0], start_chan_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_over_debounce();
    test_under_to_over();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    go_idle();
    total++;
    if (exp_chan.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d pending required=0", exp_chan.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
